clk_1hz_div: RTL and testbench
==============================

# clk_1hz_div

Clock-enable style divider that turns the 50 MHz system clock into a 1 Hz, 50 % duty square wave for slow visual logic (LED flow/shift stages, blink timers). It is a single counter plus toggle register running entirely in the system clock domain. Downstream logic samples `clk_1hz_out`, or uses `tick_1hz`, as a data-rate signal; it is not routed onto a clock tree.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: input clock frequency in Hz.
- `OUT_FREQ_HZ`, default 1: output square-wave frequency in Hz.
- Derived `HALF_CNT = CLK_FREQ_HZ / (2*OUT_FREQ_HZ)`, 25_000_000 at defaults. Integer division; the remainder is discarded.
- Derived `CNT_W = $clog2(HALF_CNT)`, minimum 1.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low. Sampled only on the rising edge of `clk`.
- `clk_1hz_out` output 1: divided square wave, registered.
- `tick_1hz` output 1: one-`clk`-cycle pulse, registered. It is high in the same cycle that `clk_1hz_out` goes 0→1.

## Operation
- Internal `cnt` of width `CNT_W`, unsigned.
- On a rising edge with `rst_n`=0:
  - `cnt` ← 0, `clk_1hz_out` ← 0, `tick_1hz` ← 0.
  - The reset outputs are visible from the first edge at which `rst_n` is sampled low.
- On a rising edge with `rst_n`=1 and `cnt` == `HALF_CNT`-1:
  - `cnt` ← 0 and `clk_1hz_out` ← ~`clk_1hz_out`.
  - `tick_1hz` ← 1 if and only if the old `clk_1hz_out` was 0.
- On any other rising edge with `rst_n`=1:
  - `cnt` ← `cnt`+1, `clk_1hz_out` holds, `tick_1hz` ← 0.
- `cnt` never exceeds `HALF_CNT`-1. The counter does not overflow or wrap beyond the terminal value.
- Elaboration error (generate-time check) if `OUT_FREQ_HZ` = 0 or `HALF_CNT` < 1.
- When `HALF_CNT` = 1, the output toggles every cycle, giving clk/2. `tick_1hz` is high every other cycle.
- Reset has priority over the terminal-count condition when both happen on the same edge.

## Timing
- Output period is 2·`HALF_CNT` `clk` cycles: 50_000_000 cycles = 1.000 s at a 20 ns clock.
- Duty cycle is exactly `HALF_CNT` high cycles and `HALF_CNT` low cycles.
- First toggle (0→1) happens on the `HALF_CNT`-th rising edge after the first edge that samples `rst_n`=1.
  - With `rst_n` released at t=20 ns and a 20 ns period, this is 25_000_000 cycles later, so `clk_1hz_out` rises at ≈0.5 s.
- `clk_1hz_out` falls 1→0 after a further `HALF_CNT` edges, at ≈1.0 s.
- `tick_1hz` spans exactly one cycle and is aligned to each rising edge of `clk_1hz_out`.
- Reset mid-period: on the next edge, output goes to 0 and the count restarts. The phase is fully re-established from release.
- Latency from reset release to first output edge is `HALF_CNT` cycles. Both outputs are glitch-free (direct flop outputs).

## Test plan
- Small parameters (`CLK_FREQ_HZ`=20, `OUT_FREQ_HZ`=1, `HALF_CNT`=10), `rst_n` low for 2 cycles then high:
  - Outputs are 0 during reset.
  - `clk_1hz_out` rises on the 10th edge after release and falls on the 20th.
  - Period is 20 cycles, with 10 cycles high.
- Same setup, `tick_1hz` check: count pulses over 100 cycles.
  - Exactly 5 pulses, each 1 cycle wide.
  - Each pulse is coincident with a 0→1 edge of `clk_1hz_out`, never with 1→0.
- Reset mid-operation: assert `rst_n`=0 at cycle 15, while the output is high.
  - Next edge: `clk_1hz_out`=0 and `tick_1hz`=0.
  - After release, the first rise is again 10 edges later.
- Edge case `CLK_FREQ_HZ`=2, `OUT_FREQ_HZ`=1 (`HALF_CNT`=1):
  - Output toggles every cycle.
  - `tick_1hz` is high on alternate cycles.
- Default parameters with a 20 ns clock, reset released at 20 ns, run 1.1 s:
  - `clk_1hz_out` rises at 500_000_020 ns ± 20 ns and falls at 1_000_000_020 ns ± 20 ns.
  - No other transitions occur.
- Odd division (`CLK_FREQ_HZ`=21, `OUT_FREQ_HZ`=1 → `HALF_CNT`=10): period is 20 cycles. The remainder is truncated with no drift inside a period.

Source files
------------

// File: rtl/clk_1hz_div.sv
// clk_1hz_div
// Divides the system clock down to a slow 50 % duty square wave plus a
// one-cycle tick that marks each rising edge of that wave. Everything runs in
// the system clock domain; both outputs are meant to be sampled as data, not
// used as a clock.

module clk_1hz_div #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int OUT_FREQ_HZ = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic clk_1hz_out,
   output logic tick_1hz
);

   // Number of clk cycles spent in each half of the output period. The guard
   // on OUT_FREQ_HZ keeps elaboration from dividing by zero before the
   // parameter check below gets a chance to report the problem.
   localparam int HALF_CNT = (OUT_FREQ_HZ > 0) ? CLK_FREQ_HZ / (2 * OUT_FREQ_HZ) : 0;

   // $clog2(HALF_CNT) bits always hold HALF_CNT-1; a divide of one still needs
   // a one-bit counter so the vector is never zero width.
   localparam int CNT_W = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;

   // Last count value of a half period, after which the output flips.
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'((HALF_CNT > 0) ? HALF_CNT - 1 : 0);

   // Refuse to build a divider that cannot produce a valid half period.
   generate
      if (OUT_FREQ_HZ == 0 || HALF_CNT < 1) begin : g_badParams
         $error("clk_1hz_div: OUT_FREQ_HZ must be nonzero and CLK_FREQ_HZ/(2*OUT_FREQ_HZ) at least 1");
      end
   endgenerate

   logic [CNT_W-1:0] r_cnt;
   logic             r_out;
   logic             r_tick;

   logic             w_atTerminal;
   logic [CNT_W-1:0] w_cntNext;
   logic             w_outNext;
   logic             w_tickNext;

   // Work out the next counter/output values: restart and flip at the end of
   // a half period, otherwise keep counting with the output held. The tick is
   // only raised when the flip takes the output from low to high.
   always_comb begin
      w_atTerminal = (r_cnt == TERM_CNT);
      w_cntNext    = r_cnt + CNT_W'(1);
      w_outNext    = r_out;
      w_tickNext   = 1'b0;
      if (w_atTerminal) begin
         w_cntNext  = '0;
         w_outNext  = ~r_out;
         w_tickNext = ~r_out;
      end
   end

   // State registers. Reset is synchronous and takes priority over the
   // terminal count, so a reset on a toggle edge still forces everything low
   // and the phase restarts cleanly from release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_out  <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cntNext;
         r_out  <= w_outNext;
         r_tick <= w_tickNext;
      end
   end

   assign clk_1hz_out = r_out;
   assign tick_1hz    = r_tick;

endmodule

// File: tb/tb_clk_1hz_div.sv
// tb_clk_1hz_div
// Drives three small divider instances (half periods of 10, 10 from an odd
// clock frequency, and 1) from one clock and one reset, and compares every
// output on every cycle against a model that derives the expected wave from
// the number of edges seen since reset release.

module tb_clk_1hz_div;

   localparam int CLK_A = 20;
   localparam int CLK_B = 21;
   localparam int CLK_C = 2;
   localparam int OUT_F = 1;

   logic clk;
   logic rst_n;
   logic outA, tickA;
   logic outB, tickB;
   logic outC, tickC;

   int checkCount;
   int errorCount;

   // Edges counted since the first edge that sampled rst_n high (0 in reset).
   int edgeCount;
   int halfA, halfB, halfC;
   int tickTally;

   clk_1hz_div #(.CLK_FREQ_HZ(CLK_A), .OUT_FREQ_HZ(OUT_F)) dutA (
      .clk(clk), .rst_n(rst_n), .clk_1hz_out(outA), .tick_1hz(tickA)
   );

   clk_1hz_div #(.CLK_FREQ_HZ(CLK_B), .OUT_FREQ_HZ(OUT_F)) dutB (
      .clk(clk), .rst_n(rst_n), .clk_1hz_out(outB), .tick_1hz(tickB)
   );

   clk_1hz_div #(.CLK_FREQ_HZ(CLK_C), .OUT_FREQ_HZ(OUT_F)) dutC (
      .clk(clk), .rst_n(rst_n), .clk_1hz_out(outC), .tick_1hz(tickC)
   );

   // Free-running system clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected square wave: high during odd-numbered half periods after release.
   function automatic logic expectedOut(input int k, input int half);
      if (k == 0) return 1'b0;
      return ((k / half) % 2) == 1;
   endfunction

   // Expected tick: only on the edge that starts an odd-numbered half period.
   function automatic logic expectedTick(input int k, input int half);
      if (k == 0) return 1'b0;
      return ((k % half) == 0) && (((k / half) % 2) == 1);
   endfunction

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Hold rst_n for one rising edge, advance the model and check all outputs.
   task automatic applyStimulus(input logic rstVal);
      rst_n = rstVal;
      @(posedge clk);
      #1;
      if (rstVal == 1'b0) edgeCount = 0;
      else                edgeCount++;
      checkOutput("A.out",  {31'b0, outA},  {31'b0, expectedOut(edgeCount, halfA)});
      checkOutput("A.tick", {31'b0, tickA}, {31'b0, expectedTick(edgeCount, halfA)});
      checkOutput("B.out",  {31'b0, outB},  {31'b0, expectedOut(edgeCount, halfB)});
      checkOutput("B.tick", {31'b0, tickB}, {31'b0, expectedTick(edgeCount, halfB)});
      checkOutput("C.out",  {31'b0, outC},  {31'b0, expectedOut(edgeCount, halfC)});
      checkOutput("C.tick", {31'b0, tickC}, {31'b0, expectedTick(edgeCount, halfC)});
      if (tickA === 1'b1) tickTally++;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      edgeCount  = 0;
      tickTally  = 0;
      halfA = CLK_A / (2 * OUT_F);
      halfB = CLK_B / (2 * OUT_F);
      halfC = CLK_C / (2 * OUT_F);
      rst_n = 1'b0;

      $display("[TB] start: half periods %0d/%0d/%0d", halfA, halfB, halfC);

      // Two reset cycles, then 100 free-running cycles with a pulse count.
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      tickTally = 0;
      for (int i = 0; i < 100; i++) applyStimulus(1'b1);
      checkOutput("A.tickCount100", tickTally, 5);

      // Reset while the output is high (15 edges after release).
      applyStimulus(1'b0);
      for (int i = 0; i < 15; i++) applyStimulus(1'b1);
      checkOutput("A.highBeforeReset", {31'b0, outA}, 1);
      applyStimulus(1'b0);
      for (int i = 0; i < 45; i++) applyStimulus(1'b1);

      // Random reset pulses sprinkled over a long run.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
